uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
- Round-robin scheduler that lets NUM_REQ byte producers share one UART transmitter (CPU store path, debug monitor, exception printer, ...).
- Sits between the requesters and the transmitter's DV/byte/active/done interface.
- Issues one byte at a time and tracks completion.
- Supports per-requester lock for atomic multi-byte messages, a configurable inter-byte gap and a completion watchdog.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GAP_CLKS, 0, idle clocks inserted after each completed byte before next arbitration (0 = none)
TIMEOUT_CLKS, 200000, max clocks from DV issue to done before abort (must exceed 10 bit times)

Ports:
i_Clock  in  1  system clock
i_Rst_L  in  1  asynchronous active-low reset
i_Req  in  NUM_REQ  request per requester; held until acked
i_Req_Byte  in  8*NUM_REQ  byte per requester, slice k = [8k+7:8k]
i_Lock  in  NUM_REQ  requester keeps ownership after its byte completes while high
o_Ack  out  NUM_REQ  one-cycle pulse: byte of requester k accepted
o_Done  out  NUM_REQ  one-cycle pulse: byte of requester k fully transmitted
o_Err  out  1  one-cycle pulse: watchdog abort
o_Busy  out  1  high in every state except IDLE
o_Owner  out  3  index of current/last owner
o_TX_DV  out  1  one-cycle start strobe to transmitter
o_TX_Byte  out  8  byte to transmitter, stable from ISSUE until next accept
i_TX_Active  in  1  transmitter busy
i_TX_Done  in  1  transmitter completion (may be high >1 cycle)

Behaviour:
- Reset (async, i_Rst_L=0):
  - State IDLE; all outputs 0.
  - RR pointer = NUM_REQ-1, so requester 0 wins first.
  - Lock flag cleared; counters 0; done edge register 0.
  - Reset mid-transfer drops the transfer silently; no o_Done or o_Err.
- States: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE:
  - Arbitrate only when i_TX_Active=0.
  - Lock flag set: only owner eligible.
    - Owner's i_Lock drops while in IDLE: flag clears and normal arbitration resumes in the same cycle.
  - Otherwise: first k with i_Req[k]=1, searching from pointer+1 mod NUM_REQ upward.
  - On grant k:
    - o_Ack[k]=1 for this cycle; latch i_Req_Byte slice k into o_TX_Byte.
    - o_Owner=k, pointer=k; go ISSUE.
- ISSUE:
  - o_TX_DV=1 for exactly one cycle; watchdog counter cleared.
  - Go WAIT_DONE.
  - Latency: req seen in IDLE -> ack same cycle -> DV next cycle.
- WAIT_DONE:
  - Completion = rising edge of i_TX_Done (registered previous value 0, current 1). A level held from a prior byte is ignored.
  - On completion:
    - o_Done[owner]=1.
    - Lock flag = i_Lock[owner] sampled this cycle.
    - Go GAP if GAP_CLKS>0, else IDLE.
  - Watchdog counter increments each cycle. Reaching TIMEOUT_CLKS-1 without completion:
    - o_Err=1; no o_Done; lock flag cleared.
    - Go IDLE; pointer stays at owner, so the next requester gets priority.
  - Completion and timeout in the same cycle: completion wins, no o_Err.
- GAP:
  - Count GAP_CLKS cycles, then IDLE; requests are not acked during GAP.
- Requests:
  - Deasserting i_Req before ack withdraws it, no side effects.
  - Requester may present its next byte immediately after its ack; it is considered only at the next IDLE.
- Invariants:
  - o_Ack and o_Done each one-hot or zero.
  - At most one byte outstanding.
  - o_TX_DV never asserted while i_TX_Active=1.
- Counter widths: $clog2 of their limits plus 1; no wrap is possible before the terminal count.

Test Plan:
- Single request: i_Req=0001, byte 0x55, transmitter model done after 100 clks -> o_Ack[0] in cycle N, o_TX_DV in N+1 with o_TX_Byte=0x55, o_Done[0] one cycle after done edge, o_Busy low after.
- Round robin: i_Req=1111 held, bytes 0xA0..0xA3 -> grant order 0,1,2,3,0; each o_Done precedes the next o_Ack; no DV while i_TX_Active high.
- Lock: req1 with i_Lock[1]=1 sends 3 bytes while req2 also requests -> order 1,1,1 then 2 after i_Lock[1] drops; req2 never acked during lock.
- Gap plus held done: GAP_CLKS=5, i_TX_Done held 2 cycles -> exactly one o_Done; next o_Ack no earlier than 6 cycles after completion.
- Watchdog: TIMEOUT_CLKS=50, model never asserts done -> o_Err pulse 50 cycles after DV, no o_Done; next grant goes to owner+1.
- Async reset asserted in WAIT_DONE -> all outputs 0 immediately; after release, requester 0 is granted first.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// Requester and transmitter signals for uart_tx_sched, grouped into one interface.
// The slave modport is the scheduler's view; the master modport drives the scheduler.
interface uart_tx_sched_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   i_Req;
    logic [8*NUM_REQ-1:0] i_Req_Byte;
    logic [NUM_REQ-1:0]   i_Lock;
    logic [NUM_REQ-1:0]   o_Ack;
    logic [NUM_REQ-1:0]   o_Done;
    logic                 o_Err;
    logic                 o_Busy;
    logic [2:0]           o_Owner;
    logic                 o_TX_DV;
    logic [7:0]           o_TX_Byte;
    logic                 i_TX_Active;
    logic                 i_TX_Done;

    modport slave (
        input  i_Req, i_Req_Byte, i_Lock, i_TX_Active, i_TX_Done,
        output o_Ack, o_Done, o_Err, o_Busy, o_Owner, o_TX_DV, o_TX_Byte
    );

    modport master (
        output i_Req, i_Req_Byte, i_Lock, i_TX_Active, i_TX_Done,
        input  o_Ack, o_Done, o_Err, o_Busy, o_Owner, o_TX_DV, o_TX_Byte
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers.
// Latency: ack is combinational in the grant cycle, TX_DV follows one cycle later.
// Backpressure: requesters hold i_Req until acked; no grant while the transmitter is active.
module uart_tx_sched #(
    parameter int NUM_REQ      = 4,
    parameter int GAP_CLKS     = 0,
    parameter int TIMEOUT_CLKS = 200000
) (
    input  logic           i_Clock,
    input  logic           i_Rst_L,
    uart_tx_sched_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CLKS) + 1;
    localparam int GAP_W = $clog2(GAP_CLKS + 1) + 1;
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CLKS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
    localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic               lock_q, lock_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [7:0]         byte_q, byte_d;
    logic               done_q;

    logic               done_edge;
    logic               gnt_vld;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   cand;
    logic               lock_hold;
    logic [NUM_REQ-1:0] ack;
    logic [NUM_REQ-1:0] done_pulse;
    logic               err;
    logic               dv;
    logic [7:0]         req_byte [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
        assign req_byte[k] = bus.i_Req_Byte[8*k +: 8];
    end

    // A done level left over from the previous byte must not complete the next one.
    assign done_edge = bus.i_TX_Done & ~done_q;

    always_comb begin
        gnt_vld   = 1'b0;
        gnt_idx   = ptr_q;
        cand      = ptr_q;
        lock_hold = lock_q && bus.i_Lock[owner_q];
        if (lock_hold) begin
            if (bus.i_Req[owner_q]) begin
                gnt_vld = 1'b1;
                gnt_idx = owner_q;
            end
        end else begin
            for (int i = 1; i <= NUM_REQ; i++) begin
                cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
                if (!gnt_vld && bus.i_Req[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        lock_d     = lock_q;
        wd_d       = wd_q;
        gap_d      = gap_q;
        byte_d     = byte_q;
        ack        = '0;
        done_pulse = '0;
        err        = 1'b0;
        dv         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (lock_q && !bus.i_Lock[owner_q]) begin
                    lock_d = 1'b0;
                end
                // Gating with reset keeps the combinational ack quiet while reset is held.
                if (i_Rst_L && !bus.i_TX_Active && gnt_vld) begin
                    ack[gnt_idx] = 1'b1;
                    byte_d       = req_byte[gnt_idx];
                    owner_d      = gnt_idx;
                    ptr_d        = gnt_idx;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                dv      = 1'b1;
                wd_d    = '0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (done_edge) begin
                    done_pulse[owner_q] = 1'b1;
                    lock_d              = bus.i_Lock[owner_q];
                    gap_d               = '0;
                    state_d             = (GAP_CLKS > 0) ? S_GAP : S_IDLE;
                end else if (wd_q == WD_LAST) begin
                    err     = 1'b1;
                    lock_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= S_IDLE;
            ptr_q   <= PTR_RST;
            owner_q <= '0;
            lock_q  <= 1'b0;
            wd_q    <= '0;
            gap_q   <= '0;
            byte_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            lock_q  <= lock_d;
            wd_q    <= wd_d;
            gap_q   <= gap_d;
            byte_q  <= byte_d;
            done_q  <= bus.i_TX_Done;
        end
    end

    assign bus.o_Ack     = ack;
    assign bus.o_Done    = done_pulse;
    assign bus.o_Err     = err;
    assign bus.o_Busy    = (state_q != S_IDLE);
    assign bus.o_Owner   = 3'(owner_q);
    assign bus.o_TX_DV   = dv;
    assign bus.o_TX_Byte = byte_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: per-requester byte queues, a transmitter model and a grant scoreboard.
// Table vectors cover arbitration and lock orders; directed sequences cover lock hold, watchdog and reset.
module tb_uart_tx_sched;
    localparam int NR    = 4;
    localparam int GAP   = 5;
    localparam int TMO   = 50;
    localparam int TXD   = 20;
    localparam int DHOLD = 2;

    typedef struct {
        int         idx;
        logic [7:0] b;
    } exp_t;

    typedef struct {
        logic [15:0] nb;
        logic [3:0]  lk;
        logic [7:0]  base;
        logic [31:0] seq;
        int          n;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_sched_if #(.NUM_REQ(NR)) bus ();

    uart_tx_sched #(
        .NUM_REQ     (NR),
        .GAP_CLKS    (GAP),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .i_Clock(clk),
        .i_Rst_L(rst_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_err = 0;

    logic [7:0]    rbytes [NR][8];
    int            rhead  [NR];
    int            rtail  [NR];
    logic [NR-1:0] lock_en;
    logic [NR-1:0] lock_man;
    exp_t          sb [$];
    vec_t          vt [6];

    int         pend_idx;
    logic [7:0] pend_b;
    bit         outstanding, first_in_vec, tx_start, tx_hang, tx_kill;
    int         ack_cyc, dv_cyc, done_cyc, tx_cnt, dcnt, pop_k;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive_req();
        bit has;
        for (int k = 0; k < NR; k++) begin
            has = (rhead[k] < rtail[k]);
            bus.i_Req[k] = has;
            if (has) bus.i_Req_Byte[8*k +: 8] = rbytes[k][rhead[k]];
            else     bus.i_Req_Byte[8*k +: 8] = 8'h00;
            bus.i_Lock[k] = lock_man[k] | (lock_en[k] & has);
        end
    endtask

    task automatic load(input int k, input logic [7:0] b);
        rbytes[k][rtail[k]] = b;
        rtail[k]++;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic sample();
        logic [NR-1:0] a;
        logic [NR-1:0] d;
        exp_t          e;
        a = bus.o_Ack;
        d = bus.o_Done;
        if (a != '0) begin
            chk("ack_onehot", 32'($onehot(a)), 32'd1);
            chk("ack_while_outstanding", 32'(outstanding), 32'd0);
            for (int k = 0; k < NR; k++) if (a[k]) pop_k = k;
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'(a), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("grant_order", 32'(a), 32'(1) << e.idx);
                if (!first_in_vec) chk("done_to_ack_gap", 32'(cyc - done_cyc), 32'(GAP + 1));
                pend_idx = e.idx;
                pend_b   = e.b;
            end
            outstanding  = 1'b1;
            ack_cyc      = cyc;
            first_in_vec = 1'b0;
        end
        if (bus.o_TX_DV) begin
            chk("dv_latency", 32'(cyc - ack_cyc), 32'd1);
            chk("dv_while_active", 32'(bus.i_TX_Active), 32'd0);
            chk("tx_byte", 32'(bus.o_TX_Byte), 32'(pend_b));
            chk("owner", 32'(bus.o_Owner), 32'(pend_idx));
            dv_cyc   = cyc;
            tx_start = 1'b1;
        end
        if (d != '0) begin
            if (!outstanding) begin
                chk("unexpected_done", 32'(d), 32'd0);
            end else begin
                chk("done_idx", 32'(d), 32'(1) << pend_idx);
                chk("done_time", 32'(cyc - dv_cyc), 32'(TXD + 1));
            end
            outstanding = 1'b0;
            done_cyc    = cyc;
        end
        if (bus.o_Err) begin
            n_err++;
            chk("err_time", 32'(cyc - dv_cyc), 32'(TMO));
            chk("err_without_byte", 32'(outstanding), 32'd1);
            outstanding  = 1'b0;
            first_in_vec = 1'b1;
            tx_hang      = 1'b0;
            tx_kill      = 1'b1;
        end
    endtask

    task automatic model_step();
        if (tx_kill) begin
            tx_kill         = 1'b0;
            bus.i_TX_Active = 1'b0;
            bus.i_TX_Done   = 1'b0;
        end else if (tx_start) begin
            tx_start        = 1'b0;
            bus.i_TX_Active = 1'b1;
            tx_cnt          = TXD;
        end else if (bus.i_TX_Active) begin
            if (!tx_hang) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    bus.i_TX_Active = 1'b0;
                    bus.i_TX_Done   = 1'b1;
                    dcnt            = DHOLD;
                end
            end
        end else if (bus.i_TX_Done) begin
            dcnt--;
            if (dcnt == 0) bus.i_TX_Done = 1'b0;
        end
    endtask

    task automatic flush();
        sb.delete();
        outstanding     = 1'b0;
        first_in_vec    = 1'b1;
        pop_k           = -1;
        tx_start        = 1'b0;
        tx_hang         = 1'b0;
        tx_kill         = 1'b0;
        bus.i_TX_Active = 1'b0;
        bus.i_TX_Done   = 1'b0;
        for (int k = 0; k < NR; k++) begin
            rhead[k] = 0;
            rtail[k] = 0;
        end
    endtask

    task automatic start_vec(input logic [NR-1:0] lk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        flush();
        lock_en  = lk;
        lock_man = '0;
        drive_req();
    endtask

    task automatic release_rst();
        drive_req();
        #1;
        chk("reset_outputs", 32'({bus.o_Ack, bus.o_Done, bus.o_Err, bus.o_Busy,
                                   bus.o_Owner, bus.o_TX_DV, bus.o_TX_Byte}), 32'd0);
        step(1);
        rst_n = 1'b1;
    endtask

    task automatic wait_ack(input int budget);
        int t;
        t = 0;
        while (!outstanding && t < budget) begin
            step(1);
            t++;
        end
        chk("ack_wait", 32'(outstanding), 32'd1);
    endtask

    task automatic drain(input int budget);
        int t;
        t = 0;
        while ((sb.size() != 0 || outstanding) && t < budget) begin
            step(1);
            t++;
        end
        chk("drain_left", 32'(sb.size() + (outstanding ? 1 : 0)), 32'd0);
        step(GAP + 2);
        chk("busy_after", 32'(bus.o_Busy), 32'd0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) sample();
            @(posedge clk);
            #1;
            if (pop_k >= 0) begin
                rhead[pop_k]++;
                pop_k = -1;
            end
            model_step();
            drive_req();
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "bench time limit");
    end

    initial begin
        int cnt [NR];
        int kk;
        pend_idx = 0;
        pend_b   = 8'h00;
        ack_cyc  = 0;
        dv_cyc   = 0;
        done_cyc = 0;
        tx_cnt   = 0;
        dcnt     = 0;
        lock_en  = '0;
        lock_man = '0;
        bus.i_Req      = '0;
        bus.i_Req_Byte = '0;
        bus.i_Lock     = '0;
        flush();

        // nb: byte count per requester (nibble k); seq: expected grant order (nibble i)
        vt[0] = '{16'h0001, 4'b0000, 8'h55, 32'h0000_0000, 1};
        vt[1] = '{16'h2222, 4'b0000, 8'hA0, 32'h3210_3210, 8};
        vt[2] = '{16'h0130, 4'b0010, 8'h10, 32'h0000_2111, 4};
        vt[3] = '{16'h2020, 4'b0000, 8'h40, 32'h0000_3131, 4};
        vt[4] = '{16'h2200, 4'b1000, 8'h70, 32'h0000_2332, 4};
        vt[5] = '{16'h1002, 4'b0001, 8'hC0, 32'h0000_0300, 3};

        for (int v = 0; v < 6; v++) begin
            start_vec(vt[v].lk);
            for (int k = 0; k < NR; k++) begin
                cnt[k] = 0;
                for (int j = 0; j < int'(vt[v].nb[4*k +: 4]); j++)
                    load(k, 8'(int'(vt[v].base) + k + NR * j));
            end
            for (int i = 0; i < vt[v].n; i++) begin
                kk = int'(vt[v].seq[4*i +: 4]);
                sb.push_back('{kk, 8'(int'(vt[v].base) + kk + NR * cnt[kk])});
                cnt[kk]++;
            end
            release_rst();
            drain(3000);
        end

        // Lock held with no pending byte from the owner blocks everyone until it drops in IDLE.
        start_vec('0);
        lock_man = 4'b0001;
        load(0, 8'h11);
        load(1, 8'h22);
        sb.push_back('{0, 8'h11});
        release_rst();
        wait_ack(100);
        drain(200);
        step(30);
        chk("lock_idle_busy", 32'(bus.o_Busy), 32'd0);
        first_in_vec = 1'b1;
        sb.push_back('{1, 8'h22});
        lock_man = '0;
        drive_req();
        drain(200);

        // Async reset while waiting for done: silent drop, then requester 0 wins first.
        start_vec('0);
        load(0, 8'h44);
        sb.push_back('{0, 8'h44});
        release_rst();
        wait_ack(100);
        step(5);
        chk("busy_in_wait_done", 32'(bus.o_Busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({bus.o_Ack, bus.o_Done, bus.o_Err, bus.o_Busy,
                                         bus.o_Owner, bus.o_TX_DV, bus.o_TX_Byte}), 32'd0);
        flush();
        load(1, 8'h61);
        load(0, 8'h60);
        sb.push_back('{0, 8'h60});
        sb.push_back('{1, 8'h61});
        drive_req();
        step(2);
        rst_n = 1'b1;
        drain(500);
        chk("err_count_before_watchdog", 32'(n_err), 32'd0);

        // Watchdog: hung transmitter aborts after TMO cycles, next grant goes to owner+1.
        start_vec('0);
        tx_hang = 1'b1;
        load(1, 8'h31);
        sb.push_back('{1, 8'h31});
        release_rst();
        wait_ack(100);
        load(0, 8'h30);
        load(2, 8'h32);
        sb.push_back('{2, 8'h32});
        sb.push_back('{0, 8'h30});
        drive_req();
        drain(1000);
        chk("err_count", 32'(n_err), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
